// File: rtl/wiring_step_driver_pkg.sv
// Shared types, default widths and parameter sanity helper for the Wiring step driver.
package wiring_drv_pkg;

  localparam int unsigned DEF_INPUT_WIDTH    = 3;
  localparam int unsigned DEF_OUTPUT_WIDTH   = 2;
  localparam int unsigned DEF_SETTLE_CYCLES  = 2;
  localparam int unsigned DEF_MAX_RUN_CYCLES = 255;
  localparam int unsigned DEF_CNT_WIDTH      = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRE  = 3'd1,
    S_RUN   = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } drv_state_e;

  // True when a counter of cnt_width bits can hold max_cycles.
  function automatic bit cnt_fits(input int unsigned max_cycles,
                                  input int unsigned cnt_width);
    return (cnt_width >= 32) || ((max_cycles >> cnt_width) == 0);
  endfunction

endpackage

// File: rtl/wiring_step_driver_if.sv
// Request/result handshakes plus the Wiring block pins owned by the step driver.
interface wiring_step_driver_if
  import wiring_drv_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
);

  logic                    req_valid;
  logic                    req_ready;
  logic [INPUT_WIDTH-1:0]  req_data;
  logic [INPUT_WIDTH-1:0]  wire_in;
  logic                    wire_logic_reset;
  logic                    wire_running;
  logic [OUTPUT_WIDTH-1:0] wire_out;
  logic                    res_valid;
  logic                    res_ready;
  logic [OUTPUT_WIDTH-1:0] res_data;
  logic [CNT_WIDTH-1:0]    res_cycles;
  logic                    res_timeout;
  logic                    busy;

  // Upstream requester, result consumer and Wiring block together.
  modport master (
    output req_valid, req_data, res_ready, wire_running, wire_out,
    input  req_ready, wire_in, wire_logic_reset, res_valid, res_data,
           res_cycles, res_timeout, busy
  );

  // The step driver itself.
  modport slave (
    input  req_valid, req_data, res_ready, wire_running, wire_out,
    output req_ready, wire_in, wire_logic_reset, res_valid, res_data,
           res_cycles, res_timeout, busy
  );

endinterface

// File: rtl/wiring_step_driver_settle_detect.sv
// Counts RUN cycles and consecutive quiet cycles; flags settle and timeout.
module wiring_settle_detect
  import wiring_drv_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_wire_running,
  output logic                 o_settled,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_run_cnt
);

  logic [CNT_WIDTH-1:0] r_run_cnt;
  logic [CNT_WIDTH-1:0] r_low_cnt;
  logic [CNT_WIDTH-1:0] w_run_cnt;
  logic [CNT_WIDTH-1:0] w_low_next;

  // Registers hold completed cycles, so the current RUN cycle number is one ahead.
  assign w_run_cnt  = r_run_cnt + 1'b1;
  assign w_low_next = r_low_cnt + 1'b1;

  assign o_run_cnt = w_run_cnt;
  assign o_settled = i_enable && !i_wire_running && (w_low_next == CNT_WIDTH'(SETTLE_CYCLES));
  assign o_timeout = i_enable && (w_run_cnt == CNT_WIDTH'(MAX_RUN_CYCLES));

  // Counters run only while enabled and restart from zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_cnt <= '0;
      r_low_cnt <= '0;
    end else if (!i_enable) begin
      r_run_cnt <= '0;
      r_low_cnt <= '0;
    end else begin
      r_run_cnt <= w_run_cnt;
      r_low_cnt <= i_wire_running ? '0 : w_low_next;
    end
  end

endmodule

// File: rtl/wiring_step_driver.sv
// Sequencer that fires one trigger into Wiring, waits for settle/timeout,
// captures the outputs, pulses logic_reset and returns a result.
module wiring_step_driver
  import wiring_drv_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  wiring_step_driver_if.slave  bus
);

  if (!cnt_fits(MAX_RUN_CYCLES, CNT_WIDTH) || (SETTLE_CYCLES < 1) ||
      (MAX_RUN_CYCLES < SETTLE_CYCLES)) begin : g_bad_params
    $error("wiring_step_driver: inconsistent SETTLE/MAX_RUN/CNT_WIDTH parameters");
  end

  drv_state_e              r_state;
  logic [INPUT_WIDTH-1:0]  r_wire_in;
  logic                    r_logic_reset;
  logic                    r_res_valid;
  logic [OUTPUT_WIDTH-1:0] r_res_data;
  logic [CNT_WIDTH-1:0]    r_res_cycles;
  logic                    r_res_timeout;

  logic                    w_run_en;
  logic                    w_settled;
  logic                    w_timeout;
  logic [CNT_WIDTH-1:0]    w_run_cnt;

  assign w_run_en = (r_state == S_RUN);

  wiring_settle_detect #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .MAX_RUN_CYCLES (MAX_RUN_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_settle (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (w_run_en),
    .i_wire_running (bus.wire_running),
    .o_settled      (w_settled),
    .o_timeout      (w_timeout),
    .o_run_cnt      (w_run_cnt)
  );

  // Step FSM; wire_in doubles as the latch for the accepted trigger vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wire_in     <= '0;
      r_logic_reset <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_wire_in <= bus.req_data;
            r_state   <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_wire_in <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_settled || w_timeout) begin
            r_res_data    <= bus.wire_out;
            r_res_cycles  <= w_run_cnt;
            r_res_timeout <= !w_settled;
            r_logic_reset <= 1'b1;
            r_state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_logic_reset <= 1'b0;
          r_res_valid   <= 1'b1;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_wire_in     <= '0;
          r_logic_reset <= 1'b0;
          r_res_valid   <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = (r_state == S_IDLE);
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.wire_in          = r_wire_in;
  assign bus.wire_logic_reset = r_logic_reset;
  assign bus.res_valid        = r_res_valid;
  assign bus.res_data         = r_res_data;
  assign bus.res_cycles       = r_res_cycles;
  assign bus.res_timeout      = r_res_timeout;

endmodule
